// File: rtl/arbitro_rr_fifo_pkg.sv
// Shared definitions for the round-robin FIFO arbiter.
// Holds the FSM state encoding, the default datapath geometry and the
// position of the destination field inside a word.
package arbitro_rr_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int NUM_FIFOS_DEF  = 4;
  localparam int CNT_WIDTH_DEF  = 8;

  // Destination field sits in the two MSBs of the word.
  localparam int DEST_HI = DATA_WIDTH_DEF - 1;
  localparam int DEST_LO = DATA_WIDTH_DEF - 2;
  localparam int DEST_W  = DEST_HI - DEST_LO + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVO = 2'd1,
    PAUSA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arbitro_rr_fifo_rr_selector.sv
// Combinational round-robin picker.
// Ports:
//   req   - one request bit per input FIFO
//   ptr   - index searched first
//   grant - one-hot winner (zero when nothing requested)
//   idx   - binary index of the winner
//   valid - some request was granted
// The search order is ptr, ptr+1, ... wrapping modulo N, so N must be a
// power of two for the index arithmetic to wrap correctly.
module rr_selector #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down to offset 0 so the candidate
  // closest to the pointer is the last (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/arbitro_rr_fifo.sv
// Round-robin arbiter from four input FIFOs to four output FIFOs.
// Pops one word per grant, waits one cycle for the FIFO read data, then
// pushes the word to the output FIFO named by its destination field.
// Ports:
//   clk, reset     - clock (rising edge), async active-high reset
//   fifo_empty_in  - empty flags of the input FIFOs
//   fifo_data_in   - read data of the input FIFOs, FIFO i in slice i
//   pausa_in       - pause requests from the output FIFOs
//   fifo_full_in   - full flags of the output FIFOs
//   pop_out        - one-hot pop to the input FIFOs
//   push_out       - one-hot push to the output FIFOs (registered)
//   data_out       - word on the shared output bus (registered)
//   grant_id       - index of the most recently popped input FIFO
//   activo         - FSM is in ACTIVO
//   error_arb      - sticky protocol error flag
//   contador       - forwarded-word counter, wraps
module arbitro_rr_fifo
  import arbitro_rr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_FIFOS  = NUM_FIFOS_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_FIFOS-1:0]            fifo_empty_in,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_in,
  input  logic [NUM_FIFOS-1:0]            pausa_in,
  input  logic [NUM_FIFOS-1:0]            fifo_full_in,
  output logic [NUM_FIFOS-1:0]            pop_out,
  output logic [NUM_FIFOS-1:0]            push_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [$clog2(NUM_FIFOS)-1:0]    grant_id,
  output logic                            activo,
  output logic                            error_arb,
  output logic [CNT_WIDTH-1:0]            contador
);

  localparam int IW = $clog2(NUM_FIFOS);

  arb_state_t state, state_nx;

  logic [IW-1:0]         rr_ptr;
  logic [NUM_FIFOS-1:0]  last_pop;   // FIFO popped last cycle; its empty flag may be stale
  logic [NUM_FIFOS-1:0]  req;
  logic [NUM_FIFOS-1:0]  sel_grant;
  logic [IW-1:0]         sel_idx;
  logic                  sel_valid;
  logic                  inflight;   // a pop was issued last cycle, data arrives now
  logic                  any_data;
  logic                  any_pausa;
  logic [DATA_WIDTH-1:0] word_sel;
  logic [NUM_FIFOS-1:0]  dest_oh;

  assign any_data  = |(~fifo_empty_in);
  assign any_pausa = |pausa_in;
  assign req       = ~fifo_empty_in & ~last_pop;

  rr_selector #(.N(NUM_FIFOS), .IW(IW)) u_sel (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (sel_grant),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_data && !any_pausa) state_nx = ACTIVO;
      ACTIVO:  if (any_pausa)              state_nx = PAUSA;
               else if (!any_data)         state_nx = IDLE;
      PAUSA:   if (!any_pausa)             state_nx = any_data ? ACTIVO : IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  // Pops are also gated by the live pause so a pause arriving in ACTIVO
  // stops new pops in that very cycle.
  always_comb begin
    activo  = (state == ACTIVO);
    pop_out = '0;
    if (activo && !any_pausa && sel_valid) pop_out = sel_grant;
  end

  // ---------------- pop bookkeeping ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      last_pop <= '0;
      inflight <= 1'b0;
      grant_id <= '0;
    end else begin
      last_pop <= pop_out;
      inflight <= |pop_out;
      if (|pop_out) begin
        grant_id <= sel_idx;
        rr_ptr   <= sel_idx + IW'(1);
      end
    end
  end

  // ---------------- data stage ----------------
  always_comb begin
    word_sel = fifo_data_in[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    dest_oh  = '0;
    dest_oh[word_sel[DATA_WIDTH-1 -: IW]] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_out <= '0;
      data_out <= '0;
      contador <= '0;
    end else if (inflight) begin
      push_out <= dest_oh;
      data_out <= word_sel;
      contador <= contador + CNT_WIDTH'(1);
    end else begin
      push_out <= '0;
    end
  end

  // Sticky: push into a full FIFO, or pop of an empty one (cannot happen
  // by construction; kept as a guard against upstream flag glitches).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_arb <= 1'b0;
    else if ((|(push_out & fifo_full_in)) || (|(pop_out & fifo_empty_in)))
      error_arb <= 1'b1;
  end

endmodule

// File: tb/tb_arbitro_rr_fifo.sv
// Randomized bench for arbitro_rr_fifo with behavioural input FIFOs and a
// cycle-level reference model of the arbitration rules.
module tb_arbitro_rr_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty_in;
  logic [23:0] fifo_data_in;
  logic [3:0]  pausa_in;
  logic [3:0]  fifo_full_in;
  logic [3:0]  pop_out;
  logic [3:0]  push_out;
  logic [5:0]  data_out;
  logic [1:0]  grant_id;
  logic        activo;
  logic        error_arb;
  logic [7:0]  contador;

  always #5 clk = ~clk;

  arbitro_rr_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty_in (fifo_empty_in),
    .fifo_data_in  (fifo_data_in),
    .pausa_in      (pausa_in),
    .fifo_full_in  (fifo_full_in),
    .pop_out       (pop_out),
    .push_out      (push_out),
    .data_out      (data_out),
    .grant_id      (grant_id),
    .activo        (activo),
    .error_arb     (error_arb),
    .contador      (contador)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural input FIFOs
  logic [5:0] q [4][$];
  logic [5:0] dout [4];
  assign fifo_data_in = {dout[3], dout[2], dout[1], dout[0]};

  task automatic upd_empty();
    for (int i = 0; i < 4; i++) fifo_empty_in[i] = (q[i].size() == 0);
  endtask

  // Round-robin rule: first non-masked requester starting at pointer p.
  function automatic logic [3:0] rr_pick(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (rq[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  // Reference model state
  int         mstate;  // 0 idle, 1 active, 2 paused
  int         mptr;
  logic [3:0] mlast;
  logic       pv0, pv1;
  logic [5:0] pw0, pw1;
  logic [1:0] mgid;
  logic [5:0] mdata;
  logic [7:0] mcnt;
  logic       merr;
  logic       wrap_seen;

  task automatic model_clear();
    mstate = 0; mptr = 0; mlast = '0;
    pv0 = 0; pv1 = 0; pw0 = '0; pw1 = '0;
    mgid = '0; mdata = '0; mcnt = '0; merr = 0;
  endtask

  initial begin
    logic [3:0] exp_pop, exp_push, pop_s;
    int         idx;
    logic       nonempty;

    reset = 1'b1; pausa_in = '0; fifo_full_in = '0;
    for (int i = 0; i < 4; i++) dout[i] = '0;
    upd_empty();
    model_clear();
    wrap_seen = 0;

    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clk);
      // ---- predicted outputs for this cycle ----
      exp_pop = '0;
      if (!reset && mstate == 1 && pausa_in == 0)
        exp_pop = rr_pick(~fifo_empty_in & ~mlast, mptr);
      exp_push = '0;
      if (pv1) begin
        exp_push = 4'b0001 << pw1[5:4];
        mdata    = pw1;
        mcnt     = mcnt + 8'd1;
      end
      chk("pop_out",   pop_out,   exp_pop);
      chk("activo",    activo,    mstate == 1);
      chk("push_out",  push_out,  exp_push);
      chk("data_out",  data_out,  mdata);
      chk("contador",  contador,  mcnt);
      chk("grant_id",  grant_id,  mgid);
      chk("error_arb", error_arb, merr);
      if (cyc > 400 && pv1 && contador == 8'd0) wrap_seen = 1;
      pop_s = pop_out;

      // ---- advance the model ----
      if (!reset) begin
        if (|(exp_push & fifo_full_in)) merr = 1;
        pw1 = pw0; pv1 = pv0;
        pv0 = |exp_pop;
        if (|exp_pop) begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (exp_pop[k]) idx = k;
          pw0  = q[idx][0];
          mgid = idx[1:0];
          mptr = (idx + 1) % 4;
        end
        mlast = exp_pop;
        nonempty = |(~fifo_empty_in);
        case (mstate)
          0: if (nonempty && pausa_in == 0) mstate = 1;
          1: if (pausa_in != 0) mstate = 2; else if (!nonempty) mstate = 0;
          default: if (pausa_in == 0) mstate = nonempty ? 1 : 0;
        endcase
      end

      @(posedge clk); #1;
      // Input FIFOs present the popped word one cycle after the pop.
      for (int i = 0; i < 4; i++)
        if (pop_s[i] && q[i].size() > 0) dout[i] = q[i].pop_front();

      // ---- stimulus ----
      if (cyc == 1) reset = 1'b0;
      if (cyc == 3) q[2].push_back(6'b01_0011);
      if (cyc == 40)
        for (int i = 0; i < 4; i++)
          repeat (3) q[i].push_back(6'($urandom));
      if (cyc >= 80 && cyc < 300) begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 4) == 0) q[i].push_back(6'($urandom));
        if ($urandom_range(0, 9) == 0)  pausa_in = pausa_in ^ 4'b0010;
        if ($urandom_range(0, 24) == 0) pausa_in = pausa_in ^ 4'b0100;
      end
      if (cyc == 300) begin
        pausa_in     = '0;
        fifo_full_in = 4'b1000;
        q[0].push_back(6'b11_0101);
      end
      if (cyc > 300 && cyc < 360)
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 3) == 0) q[i].push_back({2'b11, 4'($urandom)});
      if (cyc == 359) chk("err_sticky", error_arb, 1'b1);
      if (cyc == 360) begin
        reset = 1'b1;
        #1;
        chk("rst_pop",   pop_out,   4'b0);
        chk("rst_push",  push_out,  4'b0);
        chk("rst_data",  data_out,  6'b0);
        chk("rst_gid",   grant_id,  2'b0);
        chk("rst_act",   activo,    1'b0);
        chk("rst_err",   error_arb, 1'b0);
        chk("rst_cnt",   contador,  8'b0);
        model_clear();
      end
      if (cyc == 363) begin
        reset        = 1'b0;
        fifo_full_in = '0;
      end
      if (cyc > 363 && cyc < 1000)
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 2) == 0) q[i].push_back(6'($urandom));
      upd_empty();
    end

    chk("cnt_wrap",  wrap_seen, 1'b1);
    chk("err_final", error_arb, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_fifo.md
Name: arbitro_rr_fifo

Overview:
- Round-robin arbiter between the four input FIFOs of the LogicaMaster datapath and the four output FIFOs downstream.
- Pops one 6-bit word per grant from a non-empty input FIFO.
- Routes each word to one output FIFO, chosen by the destination field in bits [5:4].
- Stops issuing pops while any downstream FIFO signals Pausa. This back-pressures the input FIFOs and never overflows the outputs.

Parameters:
- DATA_WIDTH, 6, word width; destination field is bits [DATA_WIDTH-1:DATA_WIDTH-2].
- NUM_FIFOS, 4, number of input FIFOs and output FIFOs; fixed at 4 in this revision.
- CNT_WIDTH, 8, width of the forwarded-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty_in  input  4  Fifo_Empty from input FIFOs 0..3.
- fifo_data_in  input  24  Fifo_Data_out of input FIFOs; FIFO i occupies bits [6i+5:6i].
- pausa_in  input  4  Pausa from output FIFOs 0..3.
- fifo_full_in  input  4  Fifo_Full from output FIFOs 0..3.
- pop_out  output  4  one-hot pop to input FIFOs.
- push_out  output  4  one-hot push to output FIFOs.
- data_out  output  6  word to output FIFOs, shared bus.
- grant_id  output  2  index of the input FIFO popped in the previous cycle.
- activo  output  1  high in state ACTIVO.
- error_arb  output  1  sticky error flag.
- contador  output  8  number of words forwarded, wraps.

Behaviour:
- Reset (asynchronous, active-high) forces the following. Release takes effect on the next clk edge.
  - pop_out=0, push_out=0, data_out=0, grant_id=0.
  - activo=0, error_arb=0, contador=0.
  - RR pointer=0, state=IDLE, in-flight flag=0.
- Read latency: input FIFO data is valid on fifo_data_in in cycle n+1 when pop is issued in cycle n.
  - The stage registers the pop index; in n+1 it selects that FIFO's data and decodes the destination.
  - push_out[dest] and data_out are registered outputs, asserted in cycle n+2.
  - Pop-to-push latency: 2 clocks.
- States:
  - IDLE: no pops. Go to ACTIVO when any fifo_empty_in bit is 0 and pausa_in==0.
  - ACTIVO: one pop per cycle to the RR winner.
    - Go to PAUSA if any pausa_in bit is 1.
    - Go to IDLE if all input FIFOs report empty.
  - PAUSA: no new pops. Go to ACTIVO when pausa_in==0 and some input is non-empty; otherwise go to IDLE.
- RR selection:
  - Search starts at pointer p, checking p, p+1, p+2, p+3 mod 4, skipping empty FIFOs.
  - After a grant to i, p becomes i+1 mod 4.
  - Pointer is unchanged when nothing is granted.
- Empty handling:
  - The block never pops a FIFO whose fifo_empty_in=1 in the same cycle.
  - A FIFO popped in cycle n is not granted again in n+1 while its empty flag may be stale. This costs one bubble per back-to-back grant to the same FIFO.
- In-flight words:
  - Words popped before Pausa was seen are still pushed; downstream Almost_Full headroom absorbs them.
  - Entering PAUSA does not cancel the pipeline; up to 2 words complete.
- Destination: dest = word[5:4]; push_out = 1<<dest; data_out carries the full 6-bit word unmodified.
- Error conditions:
  - error_arb is set if push_out[d] is asserted while fifo_full_in[d]=1.
  - error_arb is set if a pop is requested while the target empty flag is 1 (defensive check).
  - error_arb stays set until reset.
- contador increments on every push and wraps from 255 to 0.
- Reset mid-operation discards in-flight words without pushing them. Outputs return to reset values immediately.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, ACTIVO=2'd1, PAUSA=2'd2;
  - the DATA_WIDTH and NUM_FIFOS defaults;
  - the destination-field bit positions.
- Sub-module rr_selector is combinational: inputs are 4-bit request and 2-bit pointer; outputs are one-hot grant, 2-bit index and valid.
- FSM, pipeline registers, error logic and counter stay in the top module.

Test Plan:
- Reset asserted mid-transfer → all outputs return to 0 at once; no push of the in-flight word after release.
- Only FIFO 2 non-empty, holding word 6'b01_0011 → pop_out=4'b0100, then 2 cycles later push_out=4'b0010, data_out=6'h13, contador=1.
- All four FIFOs non-empty, pointer=0 → grants in the order 0,1,2,3,0; grant_id follows the same sequence one cycle after each pop.
- pausa_in[1] rises while ACTIVO → no pop the following cycle; at most 2 pushes complete; state=PAUSA; pops resume 1 cycle after pausa_in=0.
- fifo_full_in[3]=1 forced while a word with dest=3 is in flight → error_arb=1 and stays 1 until reset.
- 256 words forwarded → contador wraps to 0; no error_arb.
